// File: rtl/twiddle_cmul_seq_if.sv
// Handshake and data bundle for twiddle_cmul_seq: input side (a, k) and output side (y).
interface twiddle_cmul_seq_if #(
  parameter int LOG2N = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a_re;
  logic [31:0]      a_im;
  logic [LOG2N-1:0] k;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y_re;
  logic [31:0]      y_im;

  modport slave (
    input  in_valid, a_re, a_im, k, out_ready,
    output in_ready, out_valid, y_re, y_im
  );

  modport master (
    output in_valid, a_re, a_im, k, out_ready,
    input  in_ready, out_valid, y_re, y_im
  );
endinterface

// File: rtl/twiddle_cmul_seq.sv
// Complex twiddle multiply y = a * W16^k: one shared float multiplier over 4 cycles, then one add/sub cycle.
// Optional macro TWIDDLE_TRIVIAL_BYPASS_EN: k in {0,4,8,12} resolved by swap/sign flip on the accept edge.
module twiddle_cmul_seq #(
  parameter int LOG2N = 4
) (
  input logic               clk,
  input logic               rst,
  twiddle_cmul_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic [31:0]      r_a_re;
  logic [31:0]      r_a_im;
  logic [LOG2N-1:0] r_k;
  logic [31:0]      r_p [4];
  logic [31:0]      r_y_re;
  logic [31:0]      r_y_im;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [63:0]      w_w;
  logic [31:0]      w_mul_a;
  logic [31:0]      w_mul_b;
  logic [31:0]      w_prod;

  function automatic logic [63:0] rom_w(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_w = {32'h3F800000, 32'h00000000};
      4'd1:    rom_w = {32'h3F6C835E, 32'hBEC3EF15};
      4'd2:    rom_w = {32'h3F3504F3, 32'hBF3504F3};
      4'd3:    rom_w = {32'h3EC3EF15, 32'hBF6C835E};
      4'd4:    rom_w = {32'h00000000, 32'hBF800000};
      4'd5:    rom_w = {32'hBEC3EF15, 32'hBF6C835E};
      4'd6:    rom_w = {32'hBF3504F3, 32'hBF3504F3};
      4'd7:    rom_w = {32'hBF6C835E, 32'hBEC3EF15};
      4'd8:    rom_w = {32'hBF800000, 32'h00000000};
      4'd9:    rom_w = {32'hBF6C835E, 32'h3EC3EF15};
      4'd10:   rom_w = {32'hBF3504F3, 32'h3F3504F3};
      4'd11:   rom_w = {32'hBEC3EF15, 32'h3F6C835E};
      4'd12:   rom_w = {32'h00000000, 32'h3F800000};
      4'd13:   rom_w = {32'h3EC3EF15, 32'h3F6C835E};
      4'd14:   rom_w = {32'h3F3504F3, 32'h3F3504F3};
      4'd15:   rom_w = {32'h3F6C835E, 32'h3EC3EF15};
      default: rom_w = 64'h0;
    endcase
  endfunction

  // Operand b is always the ROM constant; only its top 12 fraction bits enter the multiplier.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [36:0] prod;
    logic [9:0]  e;
    logic [22:0] frac;
    prod = {13'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:11]};
    e    = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'h0, prod[36]};
    frac = prod[36] ? prod[35:13] : prod[34:12];
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0) || e[9] || (e == 10'd0)) begin
      fmul = 32'h0;
    end else begin
      fmul = {a[31] ^ b[31], e[7:0], frac};
    end
  endfunction

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      n = v[i] ? 5'(23 - i) : n;
    end
    return n;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic [31:0] yy, big, sml;
    logic [23:0] mb, ms, norm;
    logic [7:0]  diff;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e;
    logic [22:0] frac;
    yy = {y[31] ^ sub, y[30:0]};
    if (yy[30:0] > x[30:0]) begin
      big = yy;
      sml = x;
    end else begin
      big = x;
      sml = yy;
    end
    mb   = (big[30:23] == 8'd0) ? 24'h0 : {1'b1, big[22:0]};
    ms   = (sml[30:23] == 8'd0) ? 24'h0 : {1'b1, sml[22:0]};
    diff = big[30:23] - sml[30:23];
    ms   = (diff >= 8'd25) ? 24'h0 : (ms >> diff);
    sum  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
    lz   = lzc24(sum[23:0]);
    norm = sum[23:0] << lz;
    if (sum[24]) begin
      e    = {2'b00, big[30:23]} + 10'd1;
      frac = sum[23:1];
    end else begin
      e    = {2'b00, big[30:23]} - {5'd0, lz};
      frac = norm[22:0];
    end
    if ((sum == 25'h0) || e[9] || (e == 10'd0)) begin
      fadd = 32'h0;
    end else begin
      fadd = {big[31], e[7:0], frac};
    end
  endfunction

  // Product schedule: cnt 0..3 -> ar*wr, ai*wi, ar*wi, ai*wr.
  always_comb begin
    w_w = rom_w(r_k);
    case (r_cnt)
      2'd0:    begin w_mul_a = r_a_re; w_mul_b = w_w[63:32]; end
      2'd1:    begin w_mul_a = r_a_im; w_mul_b = w_w[31:0];  end
      2'd2:    begin w_mul_a = r_a_re; w_mul_b = w_w[31:0];  end
      2'd3:    begin w_mul_a = r_a_im; w_mul_b = w_w[63:32]; end
      default: begin w_mul_a = 32'h0;  w_mul_b = 32'h0;      end
    endcase
    w_prod = fmul(w_mul_a, w_mul_b);
  end

`ifdef TWIDDLE_TRIVIAL_BYPASS_EN
  logic [31:0] w_byp_re;
  logic [31:0] w_byp_im;

  function automatic logic [31:0] fneg(input logic [31:0] v);
    fneg = (v[30:0] == 31'h0) ? 32'h0 : {~v[31], v[30:0]};
  endfunction

  // Quarter-turn twiddles reduce to swap and sign flip of the incoming sample.
  always_comb begin
    case (bus.k[3:2])
      2'd0:    begin w_byp_re = bus.a_re;       w_byp_im = bus.a_im;       end
      2'd1:    begin w_byp_re = bus.a_im;       w_byp_im = fneg(bus.a_re); end
      2'd2:    begin w_byp_re = fneg(bus.a_re); w_byp_im = fneg(bus.a_im); end
      2'd3:    begin w_byp_re = fneg(bus.a_im); w_byp_im = bus.a_re;       end
      default: begin w_byp_re = 32'h0;          w_byp_im = 32'h0;          end
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_a_re      <= 32'h0;
      r_a_im      <= 32'h0;
      r_k         <= '0;
      r_y_re      <= 32'h0;
      r_y_im      <= 32'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_p[i] <= 32'h0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a_re     <= bus.a_re;
            r_a_im     <= bus.a_im;
            r_k        <= bus.k;
            r_in_ready <= 1'b0;
`ifdef TWIDDLE_TRIVIAL_BYPASS_EN
            if (bus.k[1:0] == 2'b00) begin
              r_y_re      <= w_byp_re;
              r_y_im      <= w_byp_im;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_cnt   <= 2'd0;
              r_state <= S_MUL;
            end
`else
            r_cnt   <= 2'd0;
            r_state <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          r_p[r_cnt] <= w_prod;
          r_cnt      <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_y_re      <= fadd(r_p[0], r_p[1], 1'b1);
          r_y_im      <= fadd(r_p[2], r_p[3], 1'b0);
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y_re      = r_y_re;
  assign bus.y_im      = r_y_im;
endmodule

// File: tb/tb_twiddle_cmul_seq.sv
// Self-checking bench for twiddle_cmul_seq: exact vector table, real-arithmetic model for random
// stimulus, plus backpressure and mid-operation reset sequences.
module tb_twiddle_cmul_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef TWIDDLE_TRIVIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam real PI = 3.14159265358979;

  twiddle_cmul_seq_if u_if ();
  twiddle_cmul_seq u_dut (.clk(clk), .rst(rst), .bus(u_if));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ar;
    logic [31:0] ai;
    logic [3:0]  k;
    logic [31:0] er;
    logic [31:0] ei;
  } vec_t;
  vec_t vecs [8];

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic int exp_lat(input logic [3:0] k);
    return (BYP && (k[1:0] == 2'b00)) ? 0 : 5;
  endfunction

  function automatic logic [31:0] rnd_f();
    if ($urandom_range(7, 0) == 0) return 32'h0;
    return {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_real(input string name, input logic [31:0] act, input real exp, input real tol);
    real g;
    g = f2r(act);
    n_checks++;
    if (rabs(g - exp) > tol) begin
      n_fail++;
      $display("FAIL %s: got %h (%g) required %g within %g", name, act, g, exp, tol);
    end
  endtask

  // Call away from the clock edge; returns #1 after the accept edge.
  task automatic accept(input logic [31:0] ar, input logic [31:0] ai, input logic [3:0] k);
    int w = 0;
    while (u_if.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", u_if.in_ready);
    end
    u_if.a_re     = ar;
    u_if.a_im     = ai;
    u_if.k        = k;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (u_if.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] ar, input logic [31:0] ai, input logic [3:0] k,
                        output logic [31:0] yr, output logic [31:0] yi, output int lat);
    u_if.out_ready = 1'b1;
    accept(ar, ai, k);
    wait_out(lat);
    yr = u_if.y_re;
    yi = u_if.y_im;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] yr, yi, ar, ai;
    logic [3:0]  k;
    int          lat;
    real         ra, rb, wr, wi, tol;

    vecs[0] = '{32'h40000000, 32'h40400000, 4'd0,  32'h40000000, 32'h40400000};
    vecs[1] = '{32'h3F800000, 32'h40000000, 4'd4,  32'h40000000, 32'hBF800000};
    vecs[2] = '{32'h3F800000, 32'h40000000, 4'd8,  32'hBF800000, 32'hC0000000};
    vecs[3] = '{32'h3F800000, 32'h40000000, 4'd12, 32'hC0000000, 32'h3F800000};
    vecs[4] = '{32'h00000000, 32'h00000000, 4'd0,  32'h00000000, 32'h00000000};
    vecs[5] = '{32'h00000000, 32'h3F800000, 4'd8,  32'h00000000, 32'hBF800000};
    vecs[6] = '{32'hC1200000, 32'h3E800000, 4'd4,  32'h3E800000, 32'h41200000};
    vecs[7] = '{32'h40400000, 32'hC0000000, 4'd12, 32'h40000000, 32'h40400000};

    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.a_re      = 32'h0;
    u_if.a_im      = 32'h0;
    u_if.k         = 4'd0;
    u_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("reset_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("reset_y_re", u_if.y_re, 32'h0);
    chk("reset_y_im", u_if.y_im, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].ar, vecs[i].ai, vecs[i].k, yr, yi, lat);
      chk($sformatf("vec%0d_y_re", i), yr, vecs[i].er);
      chk($sformatf("vec%0d_y_im", i), yi, vecs[i].ei);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].k)));
    end

    // k=2 on a real unit input: both outputs near +-1/sqrt(2).
    run_op(32'h3F800000, 32'h00000000, 4'd2, yr, yi, lat);
    chk_real("k2_y_re", yr, 0.70710678, 0.70710678 / 4096.0);
    chk_real("k2_y_im", yi, -0.70710678, 0.70710678 / 4096.0);
    chk("k2_latency", 32'(lat), 32'd5);

    for (int i = 0; i < 40; i++) begin
      ar = rnd_f();
      ai = rnd_f();
      k  = 4'($urandom_range(15, 0));
      run_op(ar, ai, k, yr, yi, lat);
      ra  = f2r(ar);
      rb  = f2r(ai);
      wr  = $cos(2.0 * PI * real'(k) / 16.0);
      wi  = -$sin(2.0 * PI * real'(k) / 16.0);
      tol = (rabs(ra) + rabs(rb)) / 2048.0;
      chk_real($sformatf("rnd%0d_y_re", i), yr, ra * wr - rb * wi, tol);
      chk_real($sformatf("rnd%0d_y_im", i), yi, ra * wi + rb * wr, tol);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat(k)));
    end

    // Backpressure: result must hold for 10 stalled cycles, then leave in one transfer.
    u_if.out_ready = 1'b0;
    accept(32'h3F800000, 32'h40000000, 4'd4);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'(exp_lat(4'd4)));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(u_if.out_valid), 32'd1);
      chk("bp_in_ready", 32'(u_if.in_ready), 32'd0);
      chk("bp_y_re", u_if.y_re, 32'h40000000);
      chk("bp_y_im", u_if.y_im, 32'hBF800000);
    end
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(u_if.in_ready), 32'd1);

    // Reset while the multiplier is on its third product.
    accept(32'h40400000, 32'h3F800000, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("rst_y_re", u_if.y_re, 32'h0);
    chk("rst_y_im", u_if.y_im, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("rst_no_stale_out", 32'(u_if.out_valid), 32'd0);
    end
    run_op(vecs[2].ar, vecs[2].ai, vecs[2].k, yr, yi, lat);
    chk("post_rst_y_re", yr, vecs[2].er);
    chk("post_rst_y_im", yi, vecs[2].ei);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
